leg_solver: RTL and testbench

- Inverse companion to the magnitude block. The magnitude block computes floor(sqrt(x²+y²)); this block takes a hypotenuse `hyp` and one leg `leg_a`, and recovers the missing leg `leg_b = floor(sqrt(hyp² − leg_a²))`.
- Multi-cycle and iterative: one squaring/subtract cycle, then a bit-serial restoring square root, one result bit per cycle.
- Sits beside the magnitude block in the tile datapath, driven by a start/valid handshake.

---
 rtl/leg_solver.sv | 164 ++++++++++++++++
 tb/tb_leg_solver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/leg_solver.sv
// ---------------------------------------------------------------------------
// leg_solver
// Recovers the missing leg of a right triangle from its hypotenuse and one
// known leg: leg_b = floor(sqrt(hyp^2 - leg_a^2)).
// A single cycle squares and subtracts. A bit-serial restoring square root
// then resolves one result bit per cycle, MSB first.
//
// Ports
//   clk    : clock, all logic on the rising edge
//   rst_n  : synchronous active-low reset, overrides ena
//   ena    : clock enable, all state (including valid) holds while low
//   start  : request, accepted only in IDLE with ena high
//   hyp    : hypotenuse operand, captured on an accepted start
//   leg_a  : known leg operand, captured on an accepted start
//   leg_b  : recovered leg, updated together with valid
//   valid  : one-cycle pulse when leg_b/err are updated
//   err    : leg_a > hyp for the reported result
//   busy   : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module leg_solver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] hyp,
  input  logic [WIDTH-1:0] leg_a,
  output logic [WIDTH-1:0] leg_b,
  output logic             valid,
  output logic             err,
  output logic             busy
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     h_q, h_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [2*WIDTH-1:0]   d_q, d_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 errp_q, errp_d;
  logic [WIDTH-1:0]     leg_b_d;
  logic                 err_d;
  logic                 valid_d;

  logic [WIDTH-1:0]     trial;
  logic [2*WIDTH-1:0]   trial_sq;
  logic [2*WIDTH-1:0]   h_sq;
  logic [2*WIDTH-1:0]   a_sq;

  // Arithmetic helpers. The trial root sets the current bit k on top of
  // the bits already resolved; all squares are full 2*WIDTH wide.
  always_comb begin
    trial    = r_q | (WIDTH'(1) << k_q);
    trial_sq = {{WIDTH{1'b0}}, trial} * {{WIDTH{1'b0}}, trial};
    h_sq     = {{WIDTH{1'b0}}, h_q} * {{WIDTH{1'b0}}, h_q};
    a_sq     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, a_q};
  end

  assign busy = (state != IDLE);

  // Next-state and next-register logic. Everything defaults to holding;
  // valid defaults low so it is a single pulse once ena allows a step.
  always_comb begin
    state_nxt = state;
    h_d       = h_q;
    a_d       = a_q;
    r_d       = r_q;
    d_d       = d_q;
    k_d       = k_q;
    errp_d    = errp_q;
    leg_b_d   = leg_b;
    err_d     = err;
    valid_d   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          h_d       = hyp;
          a_d       = leg_a;
          state_nxt = SQUARE;
        end
      end

      SQUARE: begin
        r_d = '0;
        if (a_q > h_q) begin
          // Impossible triangle: skip the root entirely.
          errp_d    = 1'b1;
          state_nxt = DONE;
        end else begin
          // a <= h, so the difference cannot underflow.
          errp_d    = 1'b0;
          d_d       = h_sq - a_sq;
          k_d       = KW'(WIDTH - 1);
          state_nxt = ROOT;
        end
      end

      ROOT: begin
        // Keep the trial bit only if its square still fits under D.
        // Always runs all WIDTH iterations for fixed latency.
        if (trial_sq <= d_q) begin
          r_d = trial;
        end
        if (k_q == '0) begin
          state_nxt = DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end

      DONE: begin
        leg_b_d   = r_q;
        err_d     = errp_q;
        valid_d   = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q    <= '0;
      a_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
      k_q    <= '0;
      errp_q <= 1'b0;
      leg_b  <= '0;
      err    <= 1'b0;
      valid  <= 1'b0;
    end else if (ena) begin
      h_q    <= h_d;
      a_q    <= a_d;
      r_q    <= r_d;
      d_q    <= d_d;
      k_q    <= k_d;
      errp_q <= errp_d;
      leg_b  <= leg_b_d;
      err    <= err_d;
      valid  <= valid_d;
    end
  end

endmodule

// File: tb/tb_leg_solver.sv
// ---------------------------------------------------------------------------
// tb_leg_solver
// Self-checking bench for leg_solver (WIDTH=8). Directed and random requests
// are compared against a plain-arithmetic reference of the missing leg,
// including latency, handshake, clock-enable stall and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_leg_solver;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             start;
  logic [WIDTH-1:0] hyp;
  logic [WIDTH-1:0] leg_a;
  logic [WIDTH-1:0] leg_b;
  logic             valid;
  logic             err;
  logic             busy;

  int n_cmp;
  int n_bad;

  leg_solver #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .hyp   (hyp),
    .leg_a (leg_a),
    .leg_b (leg_b),
    .valid (valid),
    .err   (err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: largest r with r*r <= h*h - a*a, or error when a > h.
  function automatic int isqrt(input int d);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= d) r++;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  // Issues one request and follows it to its valid pulse. Optionally drops
  // ena for stall_len cycles starting stall_at cycles after acceptance, and
  // optionally pokes a second (ignored) start poke_at cycles after acceptance.
  task automatic applyStimulus(input int h, input int a, input int stall_at,
                               input int stall_len, input int poke_at,
                               input string tag);
    int exp_leg, exp_err, exp_lat, lat;
    exp_err = (a > h) ? 1 : 0;
    exp_leg = exp_err ? 0 : isqrt(h * h - a * a);
    exp_lat = (exp_err ? 2 : WIDTH + 2) + ((stall_at >= 0) ? stall_len : 0);

    @(posedge clk); #1;
    start = 1'b1;
    hyp   = WIDTH'(h);
    leg_a = WIDTH'(a);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, ".busy"}, 32'(busy), 32'd1);

    lat = 0;
    while (valid !== 1'b1 && lat < 60) begin
      if (lat == stall_at) ena = 1'b0;
      if (stall_at >= 0 && lat == stall_at + stall_len) ena = 1'b1;
      if (poke_at >= 0 && lat == poke_at) begin
        start = 1'b1;
        hyp   = 8'd13;
        leg_a = 8'd5;
      end
      if (poke_at >= 0 && lat == poke_at + 2) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    ena   = 1'b1;
    start = 1'b0;

    checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, ".leg_b"}, 32'(leg_b), 32'(exp_leg));
    checkOutput({tag, ".err"}, 32'(err), 32'(exp_err));

    @(posedge clk); #1;
    checkOutput({tag, ".pulse"}, 32'(valid), 32'd0);
    checkOutput({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int h, a;
    logic saw_valid;
    n_cmp = 0;
    n_bad = 0;

    // Reset held with start asserted: nothing may start.
    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b1;
    hyp   = 8'd5;
    leg_a = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.leg_b", 32'(leg_b), 32'd0);
    checkOutput("reset.valid", 32'(valid), 32'd0);
    checkOutput("reset.err", 32'(err), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset.nostart", 32'(busy), 32'd0);

    // Directed cases.
    applyStimulus(5, 3, -1, 0, -1, "basic");
    applyStimulus(255, 0, -1, 0, -1, "a_zero");
    applyStimulus(10, 10, -1, 0, -1, "a_eq_h");
    applyStimulus(200, 7, -1, 0, -1, "floor");
    applyStimulus(0, 0, -1, 0, -1, "zeros");

    // Error path, then a good request clears err.
    applyStimulus(3, 5, -1, 0, -1, "error");
    applyStimulus(5, 3, -1, 0, -1, "err_clear");

    // Start while busy is ignored; then a real 13/5 request.
    applyStimulus(5, 3, -1, 0, 3, "busy_poke");
    applyStimulus(13, 5, -1, 0, -1, "after_poke");

    // Five-cycle ena stall during ROOT.
    applyStimulus(200, 7, 4, 5, -1, "stall");

    // Reset in the middle of ROOT: no valid afterwards.
    @(posedge clk); #1;
    start = 1'b1;
    hyp   = 8'd100;
    leg_a = 8'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midreset.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midreset.busy", 32'(busy), 32'd0);
    checkOutput("midreset.leg_b", 32'(leg_b), 32'd0);
    checkOutput("midreset.valid", 32'(valid), 32'd0);
    saw_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (valid === 1'b1) saw_valid = 1'b1;
    end
    checkOutput("midreset.novalid", 32'(saw_valid), 32'd0);

    // Random requests, biased toward legal triangles.
    for (int i = 0; i < 24; i++) begin
      h = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, 255));
      else a = int'($urandom_range(0, h));
      applyStimulus(h, a, -1, 0, -1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
